// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - UART 16550 FIFO control: FCR decode, flush sequencing, strobe gating, RX timeout
module uart_fifo_ctrl #(
   parameter int RST_CYCLES = 2,
   parameter int TO_CHARS   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fcr_wr,
   input  logic [7:0] fcr_din,
   input  logic [3:0] char_bits,
   input  logic       baud_tick,
   input  logic       rx_empty,
   input  logic       rx_push_req,
   input  logic       rx_pop_req,
   input  logic       tx_push_req,
   input  logic       tx_pop_req,
   output logic       rx_push,
   output logic       rx_pop,
   output logic       tx_push,
   output logic       tx_pop,
   output logic       fifo_en,
   output logic       rx_fifo_rst,
   output logic       tx_fifo_rst,
   output logic [3:0] rx_threshold,
   output logic       char_timeout,
   output logic       busy
);

   typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

   localparam logic [3:0]  RST_LOAD = 4'(RST_CYCLES);
   localparam logic [11:0] TO_MULT  = 12'(TO_CHARS);

   state_t      state, state_nxt;
   logic [3:0]  flush_cnt, flush_cnt_nxt;
   logic        pend_rx, pend_tx, pend_rx_nxt, pend_tx_nxt;
   logic        en_change, req_rx, req_tx, req_any;
   logic [3:0]  thr_map;
   logic [3:0]  char_clamp;
   logic [11:0] to_limit, to_cnt, to_cnt_nxt;
   logic        to_clr_cnt, to_clr_flag;
   logic        unused_fcr_bits;

   assign unused_fcr_bits = ^fcr_din[5:3];

   // Toggling the enable flushes both FIFOs regardless of the reset bits
   always_comb begin
      en_change = fcr_wr & (fcr_din[0] ^ fifo_en);
      req_rx    = (fcr_wr & fcr_din[0] & fcr_din[1]) | en_change;
      req_tx    = (fcr_wr & fcr_din[0] & fcr_din[2]) | en_change;
      req_any   = req_rx | req_tx;
      case (fcr_din[7:6])
         2'b00:   thr_map = 4'h0;
         2'b01:   thr_map = 4'h3;
         2'b10:   thr_map = 4'h7;
         default: thr_map = 4'hD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_en      <= 1'b0;
         rx_threshold <= 4'h0;
      end else if (fcr_wr) begin
         fifo_en <= fcr_din[0];
         if (fcr_din[0])
            rx_threshold <= thr_map;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         flush_cnt <= 4'd0;
         pend_rx   <= 1'b0;
         pend_tx   <= 1'b0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
         pend_rx   <= pend_rx_nxt;
         pend_tx   <= pend_tx_nxt;
      end
   end

   // A write during a flush merges its requests and restarts the pulse
   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      pend_rx_nxt   = pend_rx;
      pend_tx_nxt   = pend_tx;
      case (state)
         IDLE: begin
            if (req_any) begin
               state_nxt     = FLUSH;
               flush_cnt_nxt = RST_LOAD;
               pend_rx_nxt   = req_rx;
               pend_tx_nxt   = req_tx;
            end
         end
         FLUSH: begin
            if (req_any) begin
               flush_cnt_nxt = RST_LOAD;
               pend_rx_nxt   = pend_rx | req_rx;
               pend_tx_nxt   = pend_tx | req_tx;
            end else if (flush_cnt == 4'd1) begin
               state_nxt     = IDLE;
               flush_cnt_nxt = 4'd0;
               pend_rx_nxt   = 1'b0;
               pend_tx_nxt   = 1'b0;
            end else begin
               flush_cnt_nxt = flush_cnt - 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state == FLUSH);
      rx_fifo_rst = busy & pend_rx;
      tx_fifo_rst = busy & pend_tx;
   end

   assign rx_push = rx_push_req & ~busy & ~rst;
   assign rx_pop  = rx_pop_req  & ~busy & ~rst;
   assign tx_push = tx_push_req & ~busy & ~rst;
   assign tx_pop  = tx_pop_req  & ~busy & ~rst;

   always_comb begin
      if (char_bits < 4'd7)
         char_clamp = 4'd7;
      else if (char_bits > 4'd12)
         char_clamp = 4'd12;
      else
         char_clamp = char_bits;
      to_limit    = {4'd0, char_clamp, 4'd0} * TO_MULT;
      to_clr_cnt  = rx_push | rx_pop | rx_empty | ~fifo_en | rx_fifo_rst;
      to_clr_flag = rx_pop | rx_fifo_rst | ~fifo_en;
      if (to_clr_cnt)
         to_cnt_nxt = 12'd0;
      else if (to_cnt >= to_limit)
         to_cnt_nxt = to_limit;
      else if (baud_tick)
         to_cnt_nxt = to_cnt + 12'd1;
      else
         to_cnt_nxt = to_cnt;
   end

   // The flag survives a push; only a read, a flush or disabling clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt       <= 12'd0;
         char_timeout <= 1'b0;
      end else begin
         to_cnt <= to_cnt_nxt;
         if (to_clr_flag)
            char_timeout <= 1'b0;
         else if (to_cnt_nxt == to_limit)
            char_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb/tb_uart_fifo_ctrl.sv - scoreboard bench for uart_fifo_ctrl
module tb_uart_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst, fcr_wr, baud_tick, rx_empty;
   logic [7:0] fcr_din;
   logic [3:0] char_bits;
   logic       rx_push_req, rx_pop_req, tx_push_req, tx_pop_req;
   logic       rx_push, rx_pop, tx_push, tx_pop;
   logic       fifo_en, rx_fifo_rst, tx_fifo_rst, char_timeout, busy;
   logic [3:0] rx_threshold;

   localparam int S_EN = 0, S_THR = 1, S_RXR = 2, S_TXR = 3, S_BUSY = 4, S_TO = 5;
   localparam int S_RXPUSH = 6, S_RXPOP = 7, S_TXPUSH = 8, S_TXPOP = 9;

   typedef struct {
      string      tag;
      int         sel;
      logic [11:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   uart_fifo_ctrl #(.RST_CYCLES(2), .TO_CHARS(4)) dut (
      .clk(clk), .rst(rst), .fcr_wr(fcr_wr), .fcr_din(fcr_din),
      .char_bits(char_bits), .baud_tick(baud_tick), .rx_empty(rx_empty),
      .rx_push_req(rx_push_req), .rx_pop_req(rx_pop_req),
      .tx_push_req(tx_push_req), .tx_pop_req(tx_pop_req),
      .rx_push(rx_push), .rx_pop(rx_pop), .tx_push(tx_push), .tx_pop(tx_pop),
      .fifo_en(fifo_en), .rx_fifo_rst(rx_fifo_rst), .tx_fifo_rst(tx_fifo_rst),
      .rx_threshold(rx_threshold), .char_timeout(char_timeout), .busy(busy)
   );

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] observe(input int sel);
      case (sel)
         S_EN:     return {11'd0, fifo_en};
         S_THR:    return {8'd0, rx_threshold};
         S_RXR:    return {11'd0, rx_fifo_rst};
         S_TXR:    return {11'd0, tx_fifo_rst};
         S_BUSY:   return {11'd0, busy};
         S_TO:     return {11'd0, char_timeout};
         S_RXPUSH: return {11'd0, rx_push};
         S_RXPOP:  return {11'd0, rx_pop};
         S_TXPUSH: return {11'd0, tx_push};
         S_TXPOP:  return {11'd0, tx_pop};
         default:  return 12'hFFF;
      endcase
   endfunction

   task automatic expect_val(input string tag, input int sel, input logic [11:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic expect_st(input string tag, input logic en, input logic [3:0] thr,
                            input logic rxr, input logic txr, input logic bsy);
      expect_val({tag, "_en"},   S_EN,   {11'd0, en});
      expect_val({tag, "_thr"},  S_THR,  {8'd0, thr});
      expect_val({tag, "_rxr"},  S_RXR,  {11'd0, rxr});
      expect_val({tag, "_txr"},  S_TXR,  {11'd0, txr});
      expect_val({tag, "_busy"}, S_BUSY, {11'd0, bsy});
   endtask

   task automatic drain;
      exp_t e;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, observe(e.sel), e.exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr_fcr(input logic [7:0] v);
      fcr_din = v;
      fcr_wr  = 1'b1;
      tick();
      fcr_wr  = 1'b0;
   endtask

   task automatic run_to(input string tag, input int n);
      for (int i = 1; i <= n; i++) begin
         baud_tick = 1'b1;
         tick();
         baud_tick = 1'b0;
         if (i == n - 1) begin
            expect_val({tag, "_pre"}, S_TO, 12'd0);
            drain();
         end
         if (i == n) begin
            expect_val(tag, S_TO, 12'd1);
            drain();
         end
         repeat (3) tick();
      end
   endtask

   initial begin
      rst = 1'b1; fcr_wr = 1'b0; fcr_din = 8'h00; char_bits = 4'd10;
      baud_tick = 1'b0; rx_empty = 1'b1;
      rx_push_req = 1'b1; rx_pop_req = 1'b0; tx_push_req = 1'b0; tx_pop_req = 1'b1;
      tick(); tick();
      expect_val("rst_rx_push", S_RXPUSH, 12'd0);
      expect_val("rst_tx_pop", S_TXPOP, 12'd0);
      drain();
      rst = 1'b0; rx_push_req = 1'b0; tx_pop_req = 1'b0;
      expect_st("reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      expect_val("reset_to", S_TO, 12'd0);
      drain();

      // Enable: both FIFOs flush, strobes blocked while busy
      wr_fcr(8'hC1);
      tx_push_req = 1'b1; tx_pop_req = 1'b1; rx_pop_req = 1'b1;
      expect_st("c1_a", 1'b1, 4'hD, 1'b1, 1'b1, 1'b1);
      expect_val("c1_a_txpush", S_TXPUSH, 12'd0);
      expect_val("c1_a_txpop", S_TXPOP, 12'd0);
      expect_val("c1_a_rxpop", S_RXPOP, 12'd0);
      drain();
      tick();
      expect_st("c1_b", 1'b1, 4'hD, 1'b1, 1'b1, 1'b1);
      drain();
      tick();
      expect_st("c1_c", 1'b1, 4'hD, 1'b0, 1'b0, 1'b0);
      expect_val("c1_c_txpush", S_TXPUSH, 12'd1);
      expect_val("c1_c_txpop", S_TXPOP, 12'd1);
      expect_val("c1_c_rxpop", S_RXPOP, 12'd1);
      drain();
      tx_push_req = 1'b0; tx_pop_req = 1'b0; rx_pop_req = 1'b0;

      wr_fcr(8'h43);
      rx_push_req = 1'b1;
      expect_st("43_a", 1'b1, 4'h3, 1'b1, 1'b0, 1'b1);
      expect_val("43_a_rxpush", S_RXPUSH, 12'd0);
      drain();
      tick();
      expect_st("43_b", 1'b1, 4'h3, 1'b1, 1'b0, 1'b1);
      expect_val("43_b_rxpush", S_RXPUSH, 12'd0);
      drain();
      tick();
      expect_st("43_c", 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
      expect_val("43_c_rxpush", S_RXPUSH, 12'd1);
      drain();
      rx_push_req = 1'b0;

      // Back-to-back writes merge and extend the flush
      wr_fcr(8'h85);
      expect_st("85", 1'b1, 4'h7, 1'b0, 1'b1, 1'b1);
      drain();
      wr_fcr(8'h03);
      expect_st("03_a", 1'b1, 4'h0, 1'b1, 1'b1, 1'b1);
      drain();
      tick();
      expect_st("03_b", 1'b1, 4'h0, 1'b1, 1'b1, 1'b1);
      drain();
      tick();
      expect_st("03_c", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
      drain();

      wr_fcr(8'hC1);
      expect_st("c1_noflush", 1'b1, 4'hD, 1'b0, 1'b0, 1'b0);
      drain();

      wr_fcr(8'h80);
      expect_st("80_a", 1'b0, 4'hD, 1'b1, 1'b1, 1'b1);
      drain();
      tick();
      expect_st("80_b", 1'b0, 4'hD, 1'b1, 1'b1, 1'b1);
      drain();
      tick();
      expect_st("80_c", 1'b0, 4'hD, 1'b0, 1'b0, 1'b0);
      drain();

      wr_fcr(8'h06);
      expect_st("06_dis", 1'b0, 4'hD, 1'b0, 1'b0, 1'b0);
      drain();

      // Character timeout
      wr_fcr(8'h01);
      tick(); tick();
      expect_st("01", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
      drain();
      char_bits = 4'd10;
      rx_empty  = 1'b0;
      for (int i = 1; i <= 639; i++) begin
         baud_tick = 1'b1;
         if (i == 639) rx_push_req = 1'b1;
         tick();
         baud_tick   = 1'b0;
         rx_push_req = 1'b0;
         repeat (3) tick();
      end
      expect_val("to_push639", S_TO, 12'd0);
      drain();
      run_to("to640", 640);
      rx_push_req = 1'b1;
      tick();
      rx_push_req = 1'b0;
      expect_val("to_hold_push", S_TO, 12'd1);
      drain();
      rx_pop_req = 1'b1;
      tick();
      rx_pop_req = 1'b0;
      expect_val("to_pop_clr", S_TO, 12'd0);
      drain();

      char_bits = 4'd4;
      run_to("to448", 448);
      rx_pop_req = 1'b1;
      tick();
      rx_pop_req = 1'b0;
      char_bits = 4'd15;
      run_to("to768", 768);
      rx_pop_req = 1'b1;
      tick();
      rx_pop_req = 1'b0;
      rx_empty = 1'b1;

      // Reset during a flush, and a write coincident with reset
      wr_fcr(8'h07);
      expect_val("07_busy", S_BUSY, 12'd1);
      drain();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      expect_st("rst_mid", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      expect_val("rst_mid_to", S_TO, 12'd0);
      drain();
      tick();
      expect_val("rst_mid_after", S_BUSY, 12'd0);
      drain();

      rst = 1'b1; fcr_din = 8'hC1; fcr_wr = 1'b1;
      tick();
      rst = 1'b0; fcr_wr = 1'b0;
      expect_st("rst_wr", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      drain();
      tick();
      expect_val("rst_wr_after", S_BUSY, 12'd0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
